// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream / instruction-memory bus for the program loader.
//   master : drives start, in_valid, in_data (host side / bench)
//   slave  : the loader; drives in_ready, imem_we, imem_addr, imem_wdata,
//            core_hold, busy, done, full, err, word_count
interface instr_loader_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           core_hold, busy, done, full, err, word_count
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
           core_hold, busy, done, full, err, word_count
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: assembles a little-endian byte stream into 32-bit words and
// writes them to instruction memory, holding the core while loading.
// A session ends on an all-zero word (terminator) or on filling the last
// address.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        instr_loader_if.slave (start/in_valid/in_data in;
//              in_ready, imem_we/addr/wdata, core_hold, busy, done, full,
//              err, word_count out)
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to append a one-byte
// XOR checksum after the terminator; err flags a mismatch. Without it err
// is tied low and the terminator write ends the session directly.
module instr_loader #(
  parameter int ADDR_W = 7
) (
  input  logic           clk,
  input  logic           rst,
  instr_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd3;
`endif

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [2:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
  logic              err_q, err_d;
`endif

  logic in_ready_w;

`ifdef INSTR_LOADER_CHECKSUM_EN
  assign in_ready_w = (state_q == S_RECV) || (state_q == S_CSUM);
`else
  assign in_ready_w = (state_q == S_RECV);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    done_d  = done_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RECV;
          idx_d   = 2'd0;
          addr_d  = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          done_d  = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          acc_d   = 8'h00;
          err_d   = 1'b0;
`endif
        end
      end
      S_RECV: begin
        if (bus.in_valid) begin
          case (idx_q)
            2'd0:    wdata_d[7:0]   = bus.in_data;
            2'd1:    wdata_d[15:8]  = bus.in_data;
            2'd2:    wdata_d[23:16] = bus.in_data;
            default: wdata_d[31:24] = bus.in_data;
          endcase
          idx_d = idx_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          acc_d = acc_q ^ bus.in_data;
`endif
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        // The address saturates at the top so imem_addr keeps pointing at
        // the last word written once the memory is full.
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) full_d = 1'b1;
        if (wdata_q == 32'h0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else if (addr_q == ADDR_MAX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (bus.in_valid) begin
          err_d   = (bus.in_data != acc_q);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      acc_q   <= 8'h00;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      done_q  <= done_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_hold  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = done_q;
  assign bus.full       = full_q;
  assign bus.word_count = cnt_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed stimulus for instr_loader (ADDR_W = 2) with a
// session-level reference model and a per-cycle compare process.
module tb_instr_loader;

  localparam int AW   = 2;
  localparam int MAXA = (1 << AW) - 1;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Session-level reference model
  logic [7:0]  m_b [4];
  logic [7:0]  m_acc;
  int          m_idx, m_addr, m_cnt;
  bit          m_full, m_err, m_end, m_active, m_csum;
  int          exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] got_mem [4];
  int          wr_seen = 0;

  task automatic model_clear();
    m_idx = 0; m_addr = 0; m_cnt = 0; m_acc = 8'h00;
    m_full = 0; m_err = 0; m_end = 0; m_csum = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    logic [31:0] word;
    if (m_csum) begin
      m_err  = (b != m_acc);
      m_csum = 0;
      m_end  = 1;
      return;
    end
    m_b[m_idx] = b;
    m_acc ^= b;
    m_idx++;
    if (m_idx == 4) begin
      word = {m_b[3], m_b[2], m_b[1], m_b[0]};
      exp_addr.push_back(m_addr);
      exp_data.push_back(word);
      m_cnt++;
      m_idx = 0;
      if (m_addr == MAXA) m_full = 1;
      if (word == 32'h0) begin
        if (CHK) m_csum = 1; else m_end = 1;
      end else if (m_addr == MAXA) begin
        m_end = 1;
      end
      if (m_addr != MAXA) m_addr++;
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (!rst) begin
      chk("core_hold_vs_busy", bus.core_hold, bus.busy);
      if (m_active && !m_end) chk("core_hold_in_session", bus.core_hold, 1);
      if (bus.imem_we) begin
        wr_seen++;
        got_mem[bus.imem_addr] = bus.imem_wdata;
        chk("write_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) begin
          chk("write_addr", bus.imem_addr, exp_addr.pop_front());
          chk("write_data", bus.imem_wdata, exp_data.pop_front());
        end
      end
      if (bus.done) begin
        chk("done_before_end", m_end, 1);
        chk("word_count", bus.word_count, m_cnt);
        chk("full", bus.full, m_full);
        chk("err", bus.err, m_err);
      end
      if (m_active && m_end) chk("in_ready_after_end", bus.in_ready, 0);
    end
  end

  // Called at posedge+1
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    bit ok;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    chk("byte_accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (ok) model_accept(b);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic pulse_start();
    bit ignored;
    ignored = m_active && !m_end;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (!ignored) begin
      model_clear();
      m_active = 1;
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1; break; end
    end
    chk("done_reached", ok, 1);
    @(posedge clk);
    #1;
    chk("all_writes_seen", exp_addr.size(), 0);
  endtask

  task automatic finish_session();
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(m_acc, 0);
`endif
    wait_done();
  endtask

  logic [7:0] prog [$];
  int w0;

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    m_active = 0;
    model_clear();
    foreach (got_mem[i]) got_mem[i] = 32'h0;
    #12;
    // Reset state
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_core_hold", bus.core_hold, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_word_count", bus.word_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic program: one instruction + terminator
    pulse_start();
    chk("busy_after_start", bus.busy, 1);
    chk("in_ready_after_start", bus.in_ready, 1);
    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(prog, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'hB6, 0);
    wait_done();
    chk("lit_err_good_csum", bus.err, 0);
`else
    wait_done();
`endif
    chk("lit_mem0", got_mem[0], 32'h00A00513);
    chk("lit_mem1", got_mem[1], 32'h00000000);
    chk("lit_word_count", bus.word_count, 2);
    chk("lit_full", bus.full, 0);
    chk("lit_done", bus.done, 1);
    chk("lit_addr", bus.imem_addr, 2);
    chk("lit_busy_done", bus.busy, 0);
    chk("lit_hold_done", bus.core_hold, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_holds", bus.done, 1);
    chk("word_count_holds", bus.word_count, 2);

    // Same program with in_valid toggling
    foreach (got_mem[i]) got_mem[i] = 32'hDEADBEEF;
    w0 = wr_seen;
    pulse_start();
    send_seq(prog, 1);
    finish_session();
    chk("toggle_mem0", got_mem[0], 32'h00A00513);
    chk("toggle_mem1", got_mem[1], 32'h00000000);
    chk("toggle_writes", wr_seen - w0, 2);

    // start while loading is ignored
    pulse_start();
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    pulse_start();
    chk("start_ignored_busy", bus.busy, 1);
    send_byte(8'hA0, 0);
    send_byte(8'h00, 0);
    send_seq('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
    finish_session();
    chk("ignored_word_count", bus.word_count, 2);
    chk("ignored_addr", bus.imem_addr, 2);
    chk("ignored_mem0", got_mem[0], 32'h00A00513);

    // Fill all four addresses with nonzero words
    w0 = wr_seen;
    pulse_start();
    prog = {};
    for (int i = 1; i <= 16; i++) prog.push_back(8'(i));
    send_seq(prog, 0);
    wait_done();
    chk("full_writes", wr_seen - w0, 4);
    chk("full_mem0", got_mem[0], 32'h04030201);
    chk("full_mem3", got_mem[3], 32'h100F0E0D);
    chk("full_flag", bus.full, 1);
    chk("full_done", bus.done, 1);
    chk("full_count", bus.word_count, 4);
    chk("full_addr", bus.imem_addr, 3);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("full_no_more_writes", wr_seen - w0, 4);

    // Terminator lands on the last address
    pulse_start();
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(prog, 0);
    finish_session();
    chk("term_last_mem3", got_mem[3], 32'h0);
    chk("term_last_mem2", got_mem[2], 32'hCCBBAA99);
    chk("term_last_full", bus.full, 1);
    chk("term_last_count", bus.word_count, 4);

    // Reset mid-session after six bytes
    w0 = wr_seen;
    pulse_start();
    send_seq('{8'h13, 8'h05, 8'hA0, 8'h00, 8'h11, 8'h22}, 0);
    #1;
    rst = 1'b1;
    m_active = 0;
    model_clear();
    #1;
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_imem_we", bus.imem_we, 0);
    chk("arst_core_hold", bus.core_hold, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_full", bus.full, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_addr", bus.imem_addr, 0);
    chk("arst_wdata", bus.imem_wdata, 0);
    chk("arst_word_count", bus.word_count, 0);
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    repeat (6) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("arst_writes", wr_seen - w0, 1);
    chk("arst_mem0", got_mem[0], 32'h00A00513);
    pulse_start();
    send_seq('{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    finish_session();
    chk("reload_mem0", got_mem[0], 32'hDEADBEEF);
    chk("reload_count", bus.word_count, 2);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Wrong checksum byte
    pulse_start();
    send_seq('{8'h13, 8'h05, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    send_byte(8'h00, 0);
    wait_done();
    chk("lit_err_bad_csum", bus.err, 1);
    chk("lit_done_bad_csum", bus.done, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
